cpu_step_controller: RTL and testbench
======================================

CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

Interface
REQ-001 Parameter TICK_DIV, default 2097152, is the number of clocks per stage tick (2^21 at 12 MHz).
REQ-002 Parameter DEBOUNCE_CYC, default 120000, is the number of clocks a button level must stay stable to be accepted (10 ms).
REQ-003 Port CLK_12MHz, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 Port RST_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port step_btn_n, input, 1 bit: raw active-low single-step push button.
REQ-006 Port restart_n, input, 1 bit: raw active-low restart push button.
REQ-007 Port run_en, input, 1 bit: DIP switch; 1 = free-run, 0 = single-step.
REQ-008 Port halt_in, input, 1 bit: decoded HALT opcode from the datapath, valid in DECODE.
REQ-009 Port jump_in, input, 1 bit: jump-taken flag from the datapath, valid in EXECUTE.
REQ-010 Port stage, output, 3 bits: current state encoding.
REQ-011 Ports fetch_en, decode_en, exec_en, wb_en, pc_clear, output, 1 bit each: one-clock action strobes.
REQ-012 Port halted, output, 1 bit: high while in DONE.
REQ-013 Port busy, output, 1 bit: high in FETCH, DECODE, EXECUTE or WRITEBACK.

Function
REQ-014 The prescaler counts 0..TICK_DIV-1, wraps to 0, and asserts tick for one clock when count == TICK_DIV-1.
REQ-015 States and encodings: START=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, DONE=6, PAUSE=7; codes 5 recover to START on the next clock.
REQ-016 State transitions out of START, FETCH, DECODE, EXECUTE and WRITEBACK occur only on a tick clock.
REQ-017 START: assert pc_clear on the tick, then go to FETCH if run_en=1, else to PAUSE.
REQ-018 FETCH -> DECODE. DECODE -> DONE if halt_in=1, else -> EXECUTE.
REQ-019 EXECUTE -> FETCH (run_en=1) or PAUSE (run_en=0) if jump_in=1, skipping WRITEBACK; otherwise -> WRITEBACK.
REQ-020 WRITEBACK -> FETCH if run_en=1, else -> PAUSE.
REQ-021 PAUSE -> FETCH on the clock after step_evt when run_en=0, or on a tick when run_en=1.
REQ-022 DONE is held until a restart event.
REQ-023 fetch_en, decode_en, exec_en and wb_en are high for exactly the tick clock on which the state equals FETCH, DECODE, EXECUTE or WRITEBACK respectively; at most one strobe is high per clock.
REQ-024 step_evt is a one-clock pulse on the debounced falling edge of step_btn_n.
REQ-025 A step_evt arriving outside PAUSE sets a one-deep pending flag, which is consumed at the next PAUSE; further events while the flag is set are dropped.
REQ-026 The pending flag is cleared by restart and is ignored while run_en=1.
REQ-027 A restart event (debounced falling edge of restart_n) has the highest priority: next state START, prescaler cleared, pending flag cleared, regardless of current state or tick.
REQ-028 A run_en change mid-instruction takes effect only at the next FETCH or PAUSE decision point.

Reset
REQ-029 While RST_n=0, the state is START, the prescaler and debounce counters are 0, the pending flag is 0, the debounced button levels are 1, all strobes are 0, halted=0, busy=0 and stage=0.
REQ-030 After RST_n deasserts, the first tick issues pc_clear.

Structure
REQ-031 The state encodings and the tick and debounce defaults live in the shared package cpu_pkg, which the datapath also imports.
REQ-032 The sub-module btn_debounce (2-flop synchronizer, stability counter, falling-edge pulse output) is instantiated twice, once for step and once for restart.

Verification (TICK_DIV=4, DEBOUNCE_CYC=8)
REQ-033 Reset, then run_en=1, halt_in=0, jump_in=0 -> stage follows 0,1,2,3,4,1,... every 4 clocks; pc_clear pulses once; exactly one strobe per tick.
REQ-034 run_en=0, hold step_btn_n low for 10 clocks -> one FETCH..WRITEBACK pass, then stage=7; a 5-clock glitch produces no step.
REQ-035 halt_in=1 on the DECODE tick -> stage=6 and halted=1 with no exec_en; a step press has no effect; a restart press -> stage=0.
REQ-036 jump_in=1 on the EXECUTE tick with run_en=1 -> next stage=1, wb_en never asserts for that instruction.
REQ-037 Two step presses during the EXECUTE tick wait -> exactly one extra instruction runs after PAUSE; the second press is dropped.
REQ-038 RST_n pulsed low mid-EXECUTE -> all outputs are 0 immediately (asynchronously), and the state resumes at START.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU step controller and the datapath:
//   - cpu_state_e : controller state encodings (also the 'stage' output code)
//   - TICK_DIV_DEF / DEBOUNCE_CYC_DEF : default prescaler and debounce lengths
//   - is_busy_state() : true for the four instruction-processing states
// ---------------------------------------------------------------------------
package cpu_pkg;

  // 2^21 clocks per stage tick at 12 MHz
  localparam int unsigned TICK_DIV_DEF     = 32'd2097152;
  // 10 ms of stable button level at 12 MHz
  localparam int unsigned DEBOUNCE_CYC_DEF = 32'd120000;

  // Code 5 is unused and must recover to START
  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_DONE      = 3'd6,
    ST_PAUSE     = 3'd7
  } cpu_state_e;

  function automatic logic is_busy_state(input cpu_state_e s);
    return (s == ST_FETCH) || (s == ST_DECODE) ||
           (s == ST_EXECUTE) || (s == ST_WRITEBACK);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Debounces one raw active-low push button and emits a one-clock pulse when
// the accepted level falls (button pressed).
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   btn_n      : raw active-low button input (asynchronous to clk)
//   fall_pulse : registered one-clock pulse on a debounced 1->0 transition
// ---------------------------------------------------------------------------
module btn_debounce
  import cpu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic fall_pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 32'd1) ? $clog2(DEBOUNCE_CYC) : 32'd1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 32'd1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          fall_q;
  logic          fall_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Stability counter: a differing synchronized level is accepted only after
  // it has been observed on DEBOUNCE_CYC consecutive clocks
  always_comb begin
    level_d = level_q;
    cnt_d   = {CW{1'b0}};
    fall_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
        fall_d  = ~sync2_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  // Synchronizer, accepted level, counter and pulse registers (idle level is 1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= {CW{1'b0}};
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_pulse = fall_q;

endmodule

// File: rtl/cpu_step_controller.sv
// ---------------------------------------------------------------------------
// cpu_step_controller
// Sequences a simple multi-cycle CPU through START/FETCH/DECODE/EXECUTE/
// WRITEBACK, with HALT (DONE), single-step (PAUSE) and restart support.
// Stage advances are paced by a prescaler tick.
// Ports:
//   CLK_12MHz  : system clock, rising edge
//   RST_n      : asynchronous active-low reset
//   step_btn_n : raw active-low single-step button
//   restart_n  : raw active-low restart button
//   run_en     : 1 = free-run, 0 = single-step
//   halt_in    : HALT opcode decoded (sampled in DECODE)
//   jump_in    : jump taken (sampled in EXECUTE)
//   stage      : current state code
//   fetch_en/decode_en/exec_en/wb_en/pc_clear : one-clock action strobes
//   halted     : high in DONE
//   busy       : high in FETCH, DECODE, EXECUTE, WRITEBACK
// ---------------------------------------------------------------------------
module cpu_step_controller
  import cpu_pkg::*;
#(
  parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic       CLK_12MHz,
  input  logic       RST_n,
  input  logic       step_btn_n,
  input  logic       restart_n,
  input  logic       run_en,
  input  logic       halt_in,
  input  logic       jump_in,
  output logic [2:0] stage,
  output logic       fetch_en,
  output logic       decode_en,
  output logic       exec_en,
  output logic       wb_en,
  output logic       pc_clear,
  output logic       halted,
  output logic       busy
);

  localparam int unsigned CNT_W = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 32'd1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 32'd1);

  logic             step_evt_s;
  logic             restart_evt_s;
  logic             tick_s;
  logic             tick_next_s;

  cpu_state_e       state_q;
  cpu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_q;
  logic             pend_d;
  logic             fetch_en_q,  fetch_en_d;
  logic             decode_en_q, decode_en_d;
  logic             exec_en_q,   exec_en_d;
  logic             wb_en_q,     wb_en_d;
  logic             pc_clear_q,  pc_clear_d;
  logic             halted_q,    halted_d;
  logic             busy_q,      busy_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_db (
    .clk        (CLK_12MHz),
    .rst_n      (RST_n),
    .btn_n      (step_btn_n),
    .fall_pulse (step_evt_s)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_restart_db (
    .clk        (CLK_12MHz),
    .rst_n      (RST_n),
    .btn_n      (restart_n),
    .fall_pulse (restart_evt_s)
  );

  assign tick_s = (cnt_q == TICK_LAST);

  // Next-state, prescaler, pending-step and registered-output computation
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A step outside PAUSE is remembered once; a second one finds the flag
    // already set and is lost. It is only acted upon in single-step mode.
    if (step_evt_s && (state_q != ST_PAUSE)) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      ST_START: begin
        if (tick_s) begin
          state_d = run_en ? ST_FETCH : ST_PAUSE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_FETCH: begin
        if (tick_s) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (tick_s) begin
          state_d = halt_in ? ST_DONE : ST_EXECUTE;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_EXECUTE: begin
        if (tick_s && jump_in) begin
          state_d = run_en ? ST_FETCH : ST_PAUSE;
        end else if (tick_s) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_WRITEBACK: begin
        if (tick_s) begin
          state_d = run_en ? ST_FETCH : ST_PAUSE;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_PAUSE: begin
        // Free-run resumes on a tick; single-step resumes right after a step
        if (run_en) begin
          if (tick_s) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_PAUSE;
          end
        end else if (step_evt_s || pend_q) begin
          state_d = ST_FETCH;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_START;
      end
    endcase

    // Restart overrides everything else
    if (restart_evt_s) begin
      state_d = ST_START;
      cnt_d   = {CNT_W{1'b0}};
      pend_d  = 1'b0;
    end else begin
      state_d = state_d;
    end

    // Strobes are registered: they are set up one clock early so that they
    // coincide with the tick clock of the matching state
    tick_next_s = (cnt_d == TICK_LAST);
    pc_clear_d  = tick_next_s && (state_d == ST_START);
    fetch_en_d  = tick_next_s && (state_d == ST_FETCH);
    decode_en_d = tick_next_s && (state_d == ST_DECODE);
    exec_en_d   = tick_next_s && (state_d == ST_EXECUTE);
    wb_en_d     = tick_next_s && (state_d == ST_WRITEBACK);
    halted_d    = (state_d == ST_DONE);
    busy_d      = is_busy_state(state_d);
  end

  // State machine, prescaler, pending flag and output registers
  always_ff @(posedge CLK_12MHz or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_START;
      cnt_q       <= {CNT_W{1'b0}};
      pend_q      <= 1'b0;
      pc_clear_q  <= 1'b0;
      fetch_en_q  <= 1'b0;
      decode_en_q <= 1'b0;
      exec_en_q   <= 1'b0;
      wb_en_q     <= 1'b0;
      halted_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pc_clear_q  <= pc_clear_d;
      fetch_en_q  <= fetch_en_d;
      decode_en_q <= decode_en_d;
      exec_en_q   <= exec_en_d;
      wb_en_q     <= wb_en_d;
      halted_q    <= halted_d;
      busy_q      <= busy_d;
    end
  end

  assign stage     = state_q;
  assign pc_clear  = pc_clear_q;
  assign fetch_en  = fetch_en_q;
  assign decode_en = decode_en_q;
  assign exec_en   = exec_en_q;
  assign wb_en     = wb_en_q;
  assign halted    = halted_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_step_controller
// Directed bench for cpu_step_controller with TICK_DIV=4, DEBOUNCE_CYC=8.
// ---------------------------------------------------------------------------
module tb_cpu_step_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       step_btn_n = 1'b1;
  logic       restart_n = 1'b1;
  logic       run_en = 1'b1;
  logic       halt_in = 1'b0;
  logic       jump_in = 1'b0;
  logic [2:0] stage;
  logic       fetch_en, decode_en, exec_en, wb_en, pc_clear, halted, busy;

  int n_assert = 0;
  int n_fail   = 0;
  int pc_cnt = 0, f_cnt = 0, d_cnt = 0, e_cnt = 0, w_cnt = 0, ovl_cnt = 0;

  cpu_step_controller #(.TICK_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .CLK_12MHz  (clk),
    .RST_n      (rst_n),
    .step_btn_n (step_btn_n),
    .restart_n  (restart_n),
    .run_en     (run_en),
    .halt_in    (halt_in),
    .jump_in    (jump_in),
    .stage      (stage),
    .fetch_en   (fetch_en),
    .decode_en  (decode_en),
    .exec_en    (exec_en),
    .wb_en      (wb_en),
    .pc_clear   (pc_clear),
    .halted     (halted),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Tally strobe pulses and note any clock with more than one strobe
  always @(negedge clk) begin
    if (pc_clear === 1'b1) pc_cnt++;
    if (fetch_en === 1'b1) f_cnt++;
    if (decode_en === 1'b1) d_cnt++;
    if (exec_en === 1'b1) e_cnt++;
    if (wb_en === 1'b1) w_cnt++;
    if ($countones({pc_clear, fetch_en, decode_en, exec_en, wb_en}) > 1) ovl_cnt++;
  end

  function automatic logic [9:0] all_outs();
    return {stage, pc_clear, fetch_en, decode_en, exec_en, wb_en, halted, busy};
  endfunction

  // Expected stage k clocks after reset release, free-run, no halt/jump
  function automatic int exp_stage(input int k);
    if (k < 4) return 0;
    case (((k - 4) / 4) % 4)
      0: return 1;
      1: return 2;
      2: return 3;
      default: return 4;
    endcase
  endfunction

  // Expected {pc_clear, fetch, decode, exec, wb} at clock k
  function automatic int exp_strobe(input int k);
    if ((k % 4) != 3) return 0;
    if (k == 3) return 5'b10000;
    case (exp_stage(k))
      1: return 5'b01000;
      2: return 5'b00100;
      3: return 5'b00010;
      default: return 5'b00001;
    endcase
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stage(input int s, input int lim, input string tag);
    int n = 0;
    while ((int'(stage) != s) && (n < lim)) begin
      tick_clk();
      n++;
    end
    chk(tag, int'(n < lim), 1);
  endtask

  task automatic press_step();
    step_btn_n = 1'b0;
    repeat (10) tick_clk();
    step_btn_n = 1'b1;
  endtask

  initial begin
    int base_f, base_d, base_e, base_w, base_p;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) tick_clk();
    chk("reset_outputs", int'(all_outs()), 0);
    @(negedge clk) rst_n = 1'b1;

    // Free-run sequence: stage 0,1,2,3,4,1,2 with one strobe per tick
    for (int k = 1; k <= 24; k++) begin
      tick_clk();
      chk($sformatf("run_stage_k%0d", k), int'(stage), exp_stage(k));
      chk($sformatf("run_strobe_k%0d", k),
          int'({pc_clear, fetch_en, decode_en, exec_en, wb_en}), exp_strobe(k));
    end
    chk("run_busy", int'(busy), 1);

    // Jump taken in EXECUTE skips WRITEBACK
    base_w = w_cnt;
    base_e = e_cnt;
    jump_in = 1'b1;
    repeat (8) tick_clk();
    chk("jump_next_fetch", int'(stage), 1);
    chk("jump_no_wb", w_cnt, base_w);
    chk("jump_exec_seen", e_cnt, base_e + 1);
    jump_in = 1'b0;

    // Switch to single-step: current instruction completes, then PAUSE
    run_en = 1'b0;
    base_w = w_cnt;
    repeat (16) tick_clk();
    chk("ss_pause", int'(stage), 7);
    chk("ss_wb_done", w_cnt, base_w + 1);
    repeat (8) tick_clk();
    chk("ss_pause_hold", int'(stage), 7);

    // 5-clock glitch must not step
    step_btn_n = 1'b0;
    repeat (5) tick_clk();
    step_btn_n = 1'b1;
    repeat (20) tick_clk();
    chk("glitch_no_step", int'(stage), 7);

    // Real press: one full FETCH..WRITEBACK pass back to PAUSE
    base_f = f_cnt; base_d = d_cnt; base_e = e_cnt; base_w = w_cnt;
    press_step();
    tick_clk();
    chk("step_fetch", int'(stage), 1);
    wait_stage(7, 40, "step_back_pause");
    chk("step_fetch_cnt", f_cnt, base_f + 1);
    chk("step_decode_cnt", d_cnt, base_d + 1);
    chk("step_exec_cnt", e_cnt, base_e + 1);
    chk("step_wb_cnt", w_cnt, base_w + 1);

    // Two presses while busy: one pending step, the second dropped
    run_en = 1'b1;
    press_step();
    repeat (12) tick_clk();
    press_step();
    repeat (12) tick_clk();
    run_en = 1'b0;
    wait_stage(7, 40, "pend_reach_pause");
    base_f = f_cnt;
    tick_clk();
    chk("pend_consumed", int'(stage), 1);
    wait_stage(7, 40, "pend_back_pause");
    repeat (30) tick_clk();
    chk("pend_second_dropped", int'(stage), 7);
    chk("pend_one_fetch", f_cnt, base_f + 1);

    // HALT in DECODE goes to DONE without EXECUTE
    halt_in = 1'b1;
    base_e = e_cnt;
    press_step();
    tick_clk();
    chk("halt_fetch", int'(stage), 1);
    wait_stage(6, 40, "halt_done");
    chk("halt_flags", int'({halted, busy}), 2'b10);
    chk("halt_no_exec", e_cnt, base_e);
    press_step();
    repeat (20) tick_clk();
    chk("halt_step_ignored", int'(stage), 6);

    // Restart leaves DONE; START issues pc_clear then PAUSE
    restart_n = 1'b0;
    repeat (10) tick_clk();
    restart_n = 1'b1;
    tick_clk();
    chk("restart_start", int'(stage), 0);
    chk("restart_halted", int'(halted), 0);
    halt_in = 1'b0;
    base_p = pc_cnt;
    repeat (3) tick_clk();
    chk("restart_pc_clear", int'(pc_clear), 1);
    tick_clk();
    chk("restart_pause", int'(stage), 7);
    repeat (20) tick_clk();
    chk("restart_pend_cleared", int'(stage), 7);
    chk("restart_pc_once", pc_cnt, base_p + 1);

    // Asynchronous reset in the middle of EXECUTE
    run_en = 1'b1;
    wait_stage(3, 40, "areset_reach_exec");
    tick_clk();
    chk("areset_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk("areset_outputs", int'(all_outs()), 0);
    @(negedge clk) rst_n = 1'b1;
    base_p = pc_cnt;
    tick_clk();
    chk("areset_start", int'(stage), 0);
    wait_stage(1, 10, "areset_fetch");
    chk("areset_pc_clear", pc_cnt, base_p + 1);

    chk("strobe_overlap", ovl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
